// File: rtl/bit_sampler_pkg.sv
// Shared constants, width helpers and parameter-legality check for the bit_sampler_mv family.
package bit_sampler_pkg;

  localparam int DEF_PERIOD   = 100;
  localparam int DEF_VOTES    = 5;
  localparam int DEF_TOL      = 5;
  localparam int DEF_LOCK_N   = 4;
  localparam int DEF_GLITCH_N = 3;

  // Lock and glitch counters only ever need to reach 15.
  localparam int LOCK_W   = 4;
  localparam int GLITCH_W = 4;

  function automatic int cnt_w(input int period);
    return (period <= 2) ? 1 : $clog2(period);
  endfunction

  function automatic int ones_w(input int votes);
    return (votes <= 1) ? 1 : $clog2(votes + 1);
  endfunction

  function automatic int center(input int period);
    return period / 2;
  endfunction

  function automatic int win_lo(input int period, input int votes);
    return center(period) - votes / 2;
  endfunction

  function automatic int win_hi(input int period, input int votes);
    return center(period) + votes / 2;
  endfunction

  // Edge-free interval after which lock is dropped (spans an MSF minute marker gap).
  function automatic int timeout_cycles(input int period);
    return 2 * period;
  endfunction

  function automatic int timeout_w(input int period);
    return $clog2(timeout_cycles(period) + 1);
  endfunction

  function automatic bit params_legal(input int period, input int votes, input int tol,
                                      input int lock_n, input int glitch_n);
    return (period >= 8) &&
           (votes >= 1) && (votes % 2 == 1) && (votes <= period / 2 - 1) &&
           (tol >= 0) && (tol < period / 4) &&
           (lock_n >= 1) && (lock_n <= 15) &&
           (glitch_n >= 1) && (glitch_n <= 15);
  endfunction

endpackage

// File: rtl/bit_sampler_mv_level_deglitch.sv
// Input synchroniser plus optional level filter; produces the filtered level and its change strobe.
// The filter is built only when BIT_SAMPLER_DEGLITCH_EN is defined.
module level_deglitch
  import bit_sampler_pkg::*;
#(
  parameter int GLITCH_N = DEF_GLITCH_N
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic data_i,
  output logic flt,
  output logic flt_edge
);

  logic meta;
  logic syn;
  logic flt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta  <= 1'b0;
      syn   <= 1'b0;
      flt_d <= 1'b0;
    end else begin
      meta  <= data_i;
      syn   <= meta;
      flt_d <= flt;
    end
  end

`ifdef BIT_SAMPLER_DEGLITCH_EN
  logic [GLITCH_W-1:0] stable_cnt;
  logic                flt_q;

  // A new level is adopted only after syn has disagreed with it for GLITCH_N cycles in a row.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stable_cnt <= '0;
      flt_q      <= 1'b0;
    end else if (syn == flt_q) begin
      stable_cnt <= '0;
    end else if (int'(stable_cnt) >= GLITCH_N - 1) begin
      stable_cnt <= '0;
      flt_q      <= syn;
    end else begin
      stable_cnt <= stable_cnt + GLITCH_W'(1);
    end
  end

  assign flt = flt_q;
`else
  localparam int glitch_unused = GLITCH_N;

  assign flt = syn;
`endif

  assign flt_edge = flt ^ flt_d;

endmodule

// File: rtl/bit_sampler_mv.sv
// MSF bit sampler: edge-realigned phase counter, mid-bit majority vote and timing-lock tracking.
// Optional input deglitch filter enabled by defining BIT_SAMPLER_DEGLITCH_EN.
module bit_sampler_mv
  import bit_sampler_pkg::*;
#(
  parameter int PERIOD   = DEF_PERIOD,
  parameter int VOTES    = DEF_VOTES,
  parameter int TOL      = DEF_TOL,
  parameter int LOCK_N   = DEF_LOCK_N,
  parameter int GLITCH_N = DEF_GLITCH_N
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic data_i,
  output logic bit_o,
  output logic valid_o,
  output logic unanimous_o,
  output logic locked_o
);

  localparam int CNT_W   = cnt_w(PERIOD);
  localparam int ONES_W  = ones_w(VOTES);
  localparam int WIN_LO  = win_lo(PERIOD, VOTES);
  localparam int WIN_HI  = win_hi(PERIOD, VOTES);
  localparam int TIMEOUT = timeout_cycles(PERIOD);
  localparam int Q_W     = timeout_w(PERIOD);

  if (!params_legal(PERIOD, VOTES, TOL, LOCK_N, GLITCH_N)) begin : g_bad_params
    $error("bit_sampler_mv: illegal parameter combination");
  end

  logic flt;
  logic flt_edge;

  level_deglitch #(
    .GLITCH_N(GLITCH_N)
  ) u_deglitch (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .flt     (flt),
    .flt_edge(flt_edge)
  );

  logic [CNT_W-1:0]  ph;
  logic [CNT_W-1:0]  ph_nxt;
  logic [ONES_W-1:0] ones;
  logic [ONES_W-1:0] ones_nxt;
  logic [ONES_W-1:0] ones_sum;
  logic              win_active;
  logic              win_nxt;
  logic [Q_W-1:0]    quiet;
  logic [Q_W-1:0]    quiet_nxt;
  logic [LOCK_W-1:0] lock_cnt;
  logic [LOCK_W-1:0] lock_cnt_nxt;
  logic              valid_nxt;
  logic              bit_nxt;
  logic              unan_nxt;
  logic              locked_nxt;
  logic              win_first;
  logic              win_in;
  logic              win_last;
  logic              ph_wrap;
  logic              on_time;
  logic              timeout_hit;

  // An input edge always wins: it re-zeroes the phase and abandons any vote in progress.
  always_comb begin
    win_first   = (int'(ph) == WIN_LO);
    win_in      = (int'(ph) >= WIN_LO) && (int'(ph) <= WIN_HI);
    win_last    = (int'(ph) == WIN_HI);
    ph_wrap     = (int'(ph) == PERIOD - 1);
    on_time     = (int'(ph) <= TOL) || (int'(ph) >= PERIOD - TOL);
    timeout_hit = !flt_edge && (int'(quiet) >= TIMEOUT - 1);
    ones_sum    = (win_first ? '0 : ones) + ONES_W'(flt);

    ph_nxt       = ph + CNT_W'(1);
    ones_nxt     = ones;
    win_nxt      = win_active;
    valid_nxt    = 1'b0;
    bit_nxt      = bit_o;
    unan_nxt     = unanimous_o;
    quiet_nxt    = quiet;
    lock_cnt_nxt = lock_cnt;

    if (flt_edge || ph_wrap) begin
      ph_nxt = '0;
    end

    if (flt_edge) begin
      ones_nxt = '0;
      win_nxt  = 1'b0;
    end else if (win_in) begin
      ones_nxt = ones_sum;
      win_nxt  = !win_last;
      if (win_last && (win_active || win_first)) begin
        valid_nxt = 1'b1;
        bit_nxt   = (int'(ones_sum) > VOTES / 2);
        unan_nxt  = (ones_sum == '0) || (int'(ones_sum) == VOTES);
      end
    end

    // Consecutive on-time edges build lock; a late/early edge or a long silence drops it.
    if (flt_edge) begin
      quiet_nxt = '0;
      if (!on_time) begin
        lock_cnt_nxt = '0;
      end else if (int'(lock_cnt) < LOCK_N) begin
        lock_cnt_nxt = lock_cnt + LOCK_W'(1);
      end
    end else begin
      if (int'(quiet) < TIMEOUT) begin
        quiet_nxt = quiet + Q_W'(1);
      end
      if (timeout_hit) begin
        lock_cnt_nxt = '0;
      end
    end

    locked_nxt = (int'(lock_cnt_nxt) >= LOCK_N);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ph          <= '0;
      ones        <= '0;
      win_active  <= 1'b0;
      quiet       <= '0;
      lock_cnt    <= '0;
      valid_o     <= 1'b0;
      bit_o       <= 1'b0;
      unanimous_o <= 1'b0;
      locked_o    <= 1'b0;
    end else begin
      ph          <= ph_nxt;
      ones        <= ones_nxt;
      win_active  <= win_nxt;
      quiet       <= quiet_nxt;
      lock_cnt    <= lock_cnt_nxt;
      valid_o     <= valid_nxt;
      bit_o       <= bit_nxt;
      unanimous_o <= unan_nxt;
      locked_o    <= locked_nxt;
    end
  end

endmodule

// File: tb/tb_bit_sampler_mv.sv
// Self-checking bench for bit_sampler_mv against a slot-level reference model.
// Honours BIT_SAMPLER_DEGLITCH_EN so the model tracks the same build as the DUT.
module tb_bit_sampler_mv;

  localparam int PERIOD   = 100;
  localparam int VOTES    = 5;
  localparam int TOL      = 5;
  localparam int LOCK_N   = 4;
  localparam int GLITCH_N = 3;
  localparam int WIN_HI   = PERIOD / 2 + VOTES / 2;

  logic clk;
  logic rst_i;
  logic data_i;
  logic bit_o;
  logic valid_o;
  logic unanimous_o;
  logic locked_o;

  int checks;
  int errors;
  int cyc;

  bit m_meta, m_syn, m_flt, m_flt_prev;
  int m_run;
  int m_age;
  int m_cnt;
  int m_quiet;
  bit m_valid, m_bit, m_unan, m_locked;
  bit hist[$];

  bit_sampler_mv #(
    .PERIOD  (PERIOD),
    .VOTES   (VOTES),
    .TOL     (TOL),
    .LOCK_N  (LOCK_N),
    .GLITCH_N(GLITCH_N)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .bit_o      (bit_o),
    .valid_o    (valid_o),
    .unanimous_o(unanimous_o),
    .locked_o   (locked_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: phase = cycles since the last realignment mod PERIOD; a vote is reported
  // when the phase reaches one past the window, using the last VOTES filtered levels.
  task automatic model_step(input bit d, input bit r);
    int  ph_old;
    bit  edge_old;
    int  new_age;
    int  ones;
    bit  next_flt;
    if (r) begin
      m_meta = 0; m_syn = 0; m_flt = 0; m_flt_prev = 0; m_run = 0;
      m_age = 0; m_cnt = 0; m_quiet = 0;
      m_valid = 0; m_bit = 0; m_unan = 0; m_locked = 0;
      hist.delete();
      return;
    end
    ph_old   = m_age % PERIOD;
    edge_old = (m_flt != m_flt_prev);
    hist.push_back(m_flt);
    if (hist.size() > VOTES) void'(hist.pop_front());
    new_age = edge_old ? 0 : m_age + 1;
    m_valid = ((new_age % PERIOD) == WIN_HI + 1);
    if (m_valid) begin
      ones = 0;
      foreach (hist[i]) ones += hist[i];
      m_bit  = (ones > VOTES / 2);
      m_unan = (ones == 0) || (ones == VOTES);
    end
    if (edge_old) begin
      m_quiet = 0;
      if (ph_old <= TOL || ph_old >= PERIOD - TOL) m_cnt = (m_cnt + 1 > LOCK_N) ? LOCK_N : m_cnt + 1;
      else m_cnt = 0;
    end else begin
      m_quiet++;
      if (m_quiet >= 2 * PERIOD) m_cnt = 0;
    end
    m_locked = (m_cnt >= LOCK_N);
    m_age = new_age;
`ifdef BIT_SAMPLER_DEGLITCH_EN
    next_flt = m_flt;
    if (m_syn != m_flt) begin
      m_run++;
      if (m_run >= GLITCH_N) begin
        next_flt = m_syn;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
`else
    next_flt = m_meta;
`endif
    m_flt_prev = m_flt;
    m_flt  = next_flt;
    m_syn  = m_meta;
    m_meta = d;
  endtask

  task automatic check_output();
    checks++;
    assert (valid_o === m_valid) else begin
      errors++;
      $error("[TB] FAIL valid cyc=%0d got=%b exp=%b", cyc, valid_o, m_valid);
    end
    checks++;
    assert (locked_o === m_locked) else begin
      errors++;
      $error("[TB] FAIL locked cyc=%0d got=%b exp=%b", cyc, locked_o, m_locked);
    end
    checks++;
    assert (bit_o === m_bit) else begin
      errors++;
      $error("[TB] FAIL bit cyc=%0d got=%b exp=%b", cyc, bit_o, m_bit);
    end
    if (m_valid) begin
      checks++;
      assert (unanimous_o === m_unan) else begin
        errors++;
        $error("[TB] FAIL unanimous cyc=%0d got=%b exp=%b", cyc, unanimous_o, m_unan);
      end
    end
  endtask

  task automatic apply_stimulus(input bit d, input bit r);
    data_i = d;
    rst_i  = r;
    @(posedge clk);
    model_step(d, r);
    #1;
    cyc++;
    check_output();
  endtask

  task automatic hold_level(input bit d, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(d, 1'b0);
  endtask

  // Runs at level d until the model phase equals target, bounded by two periods.
  task automatic wait_phase(input int target, input bit d);
    bit found;
    found = 0;
    for (int i = 0; i < 2 * PERIOD && !found; i++) begin
      if ((m_age % PERIOD) == target) found = 1;
      else apply_stimulus(d, 1'b0);
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("[TB] FAIL wait_phase target=%0d got=%0d", target, m_age % PERIOD);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    data_i = 1'b0;
    rst_i  = 1'b1;
    model_step(1'b0, 1'b1);
    $display("[TB] reset and constant-one run");
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1);
    checks++;
    assert (unanimous_o === 1'b0) else begin
      errors++;
      $error("[TB] FAIL reset_unanimous got=%b exp=0", unanimous_o);
    end
    hold_level(1'b1, 300);

    $display("[TB] square wave");
    for (int k = 0; k < 6; k++) hold_level(k[0] ? 1'b1 : 1'b0, PERIOD);

    $display("[TB] single-cycle glitch mid-window");
    hold_level(1'b1, 150);
    wait_phase(48, 1'b1);
    apply_stimulus(1'b0, 1'b0);
    hold_level(1'b1, 250);

    $display("[TB] short pulses around the window");
    wait_phase(46, 1'b1);
    hold_level(1'b0, 3);
    hold_level(1'b1, 200);
    wait_phase(47, 1'b1);
    hold_level(1'b0, 2);
    hold_level(1'b1, 200);

    $display("[TB] reset mid-slot");
    wait_phase(49, 1'b1);
    apply_stimulus(1'b1, 1'b1);
    checks++;
    assert (valid_o === 1'b0 && bit_o === 1'b0 && unanimous_o === 1'b0 && locked_o === 1'b0) else begin
      errors++;
      $error("[TB] FAIL reset_outputs got=%b%b%b%b exp=0000", valid_o, bit_o, unanimous_o, locked_o);
    end
    hold_level(1'b1, 200);

    $display("[TB] relock then long silence");
    for (int k = 0; k < 6; k++) hold_level(k[0] ? 1'b1 : 1'b0, PERIOD);
    hold_level(1'b1, 450);

    $display("[TB] randomized levels");
    for (int k = 0; k < 40; k++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = (k % 3 == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(90, 110));
      hold_level(lvl, len);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
